// File: rtl/daq_pkg.sv
// Shared DAQ definitions: trigger FSM state encoding and default counter widths.
package daq_pkg;

    localparam int DEFAULT_COUNTER_WIDTH = 64;
    localparam int DEFAULT_COUNT_WIDTH   = 32;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_IDLE     = 2'd1,
        ST_ARMED    = 2'd2,
        ST_FIRED    = 2'd3
    } trig_state_e;

endpackage

// File: rtl/rise_detect.sv
// Single-bit rising-edge detector: one history flop, rise = d & ~d_q.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;
    logic d_d;

    always_comb begin
        d_d = d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/counter_trigger_gen.sv
// Sample-counter trigger generator: fires when sample_counter reaches reference_counter while armed.
// Optional macro COUNTER_TRIGGER_TIMESTAMP_EN latches sample_counter at each fire.
module counter_trigger_gen
    import daq_pkg::*;
#(
    parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH,
    parameter int COUNT_WIDTH   = DEFAULT_COUNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     arm,
    input  logic [COUNTER_WIDTH-1:0] sample_counter,
    input  logic [COUNTER_WIDTH-1:0] reference_counter,
    output logic                     counter_trigger,
    output logic [1:0]               trigger_state,
    output logic [COUNT_WIDTH-1:0]   trigger_count,
    output logic [COUNTER_WIDTH-1:0] last_trigger_counter
);

    trig_state_e              state_q, state_d;
    logic                     trig_q, trig_d;
    logic [COUNT_WIDTH-1:0]   count_q, count_d;
    logic                     arm_rise;
    logic [COUNTER_WIDTH-1:0] delta;
    logic                     reached;
    logic                     fire;

    rise_detect u_arm_rise (
        .clk   (clk),
        .reset (reset),
        .d     (arm),
        .rise  (arm_rise)
    );

    // Sign of the modular difference keeps the compare correct across counter wrap.
    always_comb begin
        delta   = sample_counter - reference_counter;
        reached = ~delta[COUNTER_WIDTH-1];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_DISABLED: state_d = ST_IDLE;
            ST_IDLE:     if (arm_rise) state_d = ST_ARMED;
            ST_ARMED: begin
                if (!arm) begin
                    state_d = ST_IDLE;
                end else if (reached) begin
                    state_d = ST_FIRED;
                end
            end
            ST_FIRED:    if (!arm) state_d = ST_IDLE;
            default:     state_d = ST_DISABLED;
        endcase
        if (!enable) begin
            state_d = ST_DISABLED;
        end

        fire    = (state_q == ST_ARMED) && (state_d == ST_FIRED);
        // Downstream stage needs the trigger high whenever generation is off.
        trig_d  = (state_d == ST_DISABLED) || (state_d == ST_FIRED);
        count_d = fire ? count_q + COUNT_WIDTH'(1) : count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_DISABLED;
            trig_q  <= 1'b1;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            trig_q  <= trig_d;
            count_q <= count_d;
        end
    end

`ifdef COUNTER_TRIGGER_TIMESTAMP_EN
    logic [COUNTER_WIDTH-1:0] last_q, last_d;

    always_comb begin
        last_d = fire ? sample_counter : last_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= '0;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_trigger_counter = last_q;
`else
    assign last_trigger_counter = '0;
`endif

    assign counter_trigger = trig_q;
    assign trigger_state   = state_q;
    assign trigger_count   = count_q;

endmodule

// File: doc/counter_trigger_gen.md
COUNTER_TRIGGER_GEN -- requirements
Module: counter_trigger_gen

Interface
REQ-001 SHALL have parameter COUNTER_WIDTH, default 64, meaning the width of the sample and reference counters.
REQ-002 SHALL have parameter COUNT_WIDTH, default 32, meaning the width of the fired-trigger counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, ADC sample clock domain.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port enable, input, 1 bit: internal trigger generation enabled.
REQ-006 SHALL have port arm, input, 1 bit: arm level; a rising edge arms the generator, a low level disarms it.
REQ-007 SHALL have port sample_counter, input, COUNTER_WIDTH: free-running ADC sample index.
REQ-008 SHALL have port reference_counter, input, COUNTER_WIDTH: sample index at which to fire.
REQ-009 SHALL have port counter_trigger, output, 1 bit: trigger level consumed by the reset/trigger stage.
REQ-010 SHALL have port trigger_state, output, 2 bits: current FSM state encoding.
REQ-011 SHALL have port trigger_count, output, COUNT_WIDTH: number of FIRED entries since reset.
REQ-012 SHALL have port last_trigger_counter, output, COUNTER_WIDTH: sample_counter latched at the last fire.

Function
REQ-013 SHALL implement FSM states DISABLED=0, IDLE=1, ARMED=2, FIRED=3.
REQ-014 SHALL drive counter_trigger=1 in DISABLED and FIRED, and counter_trigger=0 in IDLE and ARMED; the downstream stage requires high when not enabled.
REQ-015 SHALL, from any state, go to DISABLED on the next edge when enable=0; enable=0 has highest priority.
REQ-016 SHALL go from DISABLED to IDLE when enable=1.
REQ-017 SHALL detect the arm rise as arm & ~arm_q, where arm_q is arm registered once.
REQ-018 SHALL go from IDLE to ARMED on an arm rise, and SHALL ignore arm high levels without an edge.
REQ-019 SHALL go from ARMED to IDLE when arm=0, and SHALL go from ARMED to FIRED when reached=1 and arm=1.
REQ-020 SHALL compute reached as bit COUNTER_WIDTH-1 of (sample_counter - reference_counter) mod 2^COUNTER_WIDTH being 0, making it wrap-around safe.
REQ-021 SHALL assert counter_trigger on the edge that enters FIRED, exactly one clk after the first sample with reached=1.
REQ-022 SHALL hold FIRED until arm=0, then go to IDLE; re-firing requires a new arm rise.
REQ-023 SHALL, when an arm rise and reached=1 occur in the same cycle in IDLE, go only to ARMED; the fire occurs on the following edge.
REQ-024 SHALL increment trigger_count on each ARMED->FIRED transition, wrapping at 2^COUNT_WIDTH.
REQ-025 SHALL register trigger_state and counter_trigger; no combinational path from any input to any output.

Reset
REQ-026 SHALL, while reset=1, set state=DISABLED, counter_trigger=1, arm_q=0, trigger_count=0, and last_trigger_counter=0.
REQ-027 SHALL abort a reset asserted mid-ARMED or mid-FIRED to DISABLED with no count increment.

Configuration
REQ-028 SHALL use macro COUNTER_TRIGGER_TIMESTAMP_EN; when defined, it latches sample_counter into last_trigger_counter on each ARMED->FIRED edge.
REQ-029 SHALL, when COUNTER_TRIGGER_TIMESTAMP_EN is undefined, tie last_trigger_counter to 0 and instantiate no latch register.

Structure
REQ-030 SHALL place the state encoding typedef and the default widths in the shared package daq_pkg.
REQ-031 SHALL use one sub-module, rise_detect (1-bit register plus AND), for the arm edge.

Verification
REQ-032 SHALL verify: enable=0 -> counter_trigger=1, trigger_state=0 for all cycles.
REQ-033 SHALL verify: enable=1, arm rise, reference=1000, sample_counter increments from 990 -> counter_trigger rises the clk after sample_counter=1000, and trigger_count=1.
REQ-034 SHALL verify with COUNTER_WIDTH=16: reference=0x0005, sample_counter crossing 0xFFFE->0x0005 -> no fire before 0x0005; fire after 0x0005.
REQ-035 SHALL verify: arm dropped while ARMED at sample 500 (reference=1000) -> IDLE, and no fire at 1000.
REQ-036 SHALL verify: arm held high after a fire, reference moved ahead -> no second fire; arm low then high -> second fire, and trigger_count=2.
REQ-037 SHALL verify: reset pulsed while FIRED -> counter_trigger=1, state=0, trigger_count=0, and last_trigger_counter=0 (with and without the macro).
